// File: rtl/load_unit.sv
// Vector load unit: turns one dispatched vector load into a single AXI read burst
// and assembles the returned beats into a masked LANES-wide result vector.
module load_unit #(
   parameter int unsigned LANES  = 16,
   parameter int unsigned WORD_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      loadValid,
   input  logic [LANES*WORD_W-1:0]   loadAddr,
   input  logic [LANES-1:0]          loadMask,
   input  logic [4:0]                loadTag,
   output logic                      loadReady,
   output logic                      initRead,
   output logic [WORD_W-1:0]         readAddress,
   output logic [7:0]                readLen,
   input  logic                      rDataValid,
   input  logic [WORD_W-1:0]         rData,
   output logic                      rDataReady,
   input  logic                      rDone,
   output logic                      resultValid,
   output logic [LANES*WORD_W-1:0]   resultData,
   output logic [LANES-1:0]          resultMask,
   output logic [4:0]                resultTag,
   output logic                      resultErr,
   input  logic                      resultReady
);

   localparam int unsigned CntW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned VecW = LANES * WORD_W;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      COLLECT = 3'd2,
      DRAIN   = 3'd3,
      RESP    = 3'd4
   } stateT;

   stateT           state;
   stateT           stateNext;
   logic [CntW-1:0] beatCnt;
   logic            loadFire;
   logic            beatFire;
   logic            lastBeat;
   logic            unusedLoadAddr;

   // Only lane 0 of the address vector seeds the burst; the other lanes are contiguous by construction.
   assign unusedLoadAddr = ^loadAddr[VecW-1:WORD_W];

   assign readLen  = 8'(LANES);
   assign loadFire = loadValid & loadReady;
   assign beatFire = rDataValid & rDataReady;
   assign lastBeat = (beatCnt == CntW'(LANES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic; a final beat arriving with rDone completes the burst normally
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (loadFire) stateNext = REQ;
         REQ:     stateNext = COLLECT;
         COLLECT: begin
            if (rDone)                      stateNext = RESP;
            else if (beatFire && lastBeat)  stateNext = DRAIN;
         end
         DRAIN:   if (rDone) stateNext = RESP;
         RESP:    if (resultReady) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Handshake outputs registered from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         loadReady   <= 1'b1;
         initRead    <= 1'b0;
         rDataReady  <= 1'b0;
         resultValid <= 1'b0;
      end else begin
         loadReady   <= (stateNext == IDLE);
         initRead    <= (stateNext == REQ) || (stateNext == COLLECT) || (stateNext == DRAIN);
         rDataReady  <= (stateNext == COLLECT);
         resultValid <= (stateNext == RESP);
      end
   end

   // Burst capture and lane assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         readAddress <= '0;
         resultMask  <= '0;
         resultTag   <= '0;
         resultErr   <= 1'b0;
         resultData  <= '0;
         beatCnt     <= '0;
      end else begin
         if (loadFire) begin
            readAddress <= loadAddr[WORD_W-1:0];
            resultMask  <= loadMask;
            resultTag   <= loadTag;
            resultErr   <= 1'b0;
            resultData  <= '0;
            beatCnt     <= '0;
         end
         if (beatFire) begin
            for (int unsigned i = 0; i < LANES; i++) begin
               if (beatCnt == CntW'(i)) begin
                  resultData[i*WORD_W +: WORD_W] <= resultMask[i] ? rData : '0;
               end
            end
            beatCnt <= beatCnt + CntW'(1);
         end
         // Burst closed by the master before every lane was delivered
         if ((state == COLLECT) && rDone && !(beatFire && lastBeat)) begin
            resultErr <= 1'b1;
         end
      end
   end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning vector lanes and burst beat count.
REQ-002 SHALL have parameter WORD_W, default 32, meaning lane and AXI data width in bits.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, meaning the system clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1, meaning the synchronous active-high reset.
REQ-006 SHALL have port loadValid, input, 1, meaning dispatch presents a vector load.
REQ-007 SHALL have port loadAddr, input, LANES*WORD_W, meaning per-lane byte addresses; lane 0 is the burst base.
REQ-008 SHALL have port loadMask, input, LANES, meaning per-lane enable.
REQ-009 SHALL have port loadTag, input, 5, meaning the destination register tag, echoed with the result.
REQ-010 SHALL have port loadReady, output, 1, meaning the unit is idle and accepts a load.
REQ-011 SHALL have port initRead, output, 1, meaning a read-burst request level to the AXI master.
REQ-012 SHALL have port readAddress, output, WORD_W, meaning the burst start address.
REQ-013 SHALL have port readLen, output, 8, meaning the burst beat count, constant LANES.
REQ-014 SHALL have port rDataValid, input, 1, meaning the AXI master presents a read beat.
REQ-015 SHALL have port rData, input, WORD_W, meaning the read beat data.
REQ-016 SHALL have port rDataReady, output, 1, meaning the unit accepts the current beat.
REQ-017 SHALL have port rDone, input, 1, meaning the AXI master has finished the burst (single-cycle pulse).
REQ-018 SHALL have port resultValid, output, 1, meaning the assembled vector is available.
REQ-019 SHALL have port resultData, output, LANES*WORD_W, meaning the loaded vector, with lane i in bits [i*WORD_W +: WORD_W].
REQ-020 SHALL have port resultMask, output, LANES, meaning the captured loadMask.
REQ-021 SHALL have port resultTag, output, 5, meaning the captured loadTag.
REQ-022 SHALL have port resultErr, output, 1, meaning the burst ended with fewer than LANES beats.
REQ-023 SHALL have port resultReady, input, 1, meaning writeback consumes the result.

Function
REQ-024 SHALL implement the states IDLE, REQ, COLLECT, DRAIN and RESP.
REQ-025 SHALL assert loadReady only in IDLE; a load is accepted in the cycle where loadValid and loadReady are both 1, and the state moves to REQ.
REQ-026 SHALL capture, on accept, loadAddr lane 0 into readAddress and loadMask, loadTag into their result registers, clear the beat counter, clear resultErr, and zero every resultData lane.
REQ-027 SHALL drive initRead=1 from the cycle after accept and hold it until the cycle after rDone is sampled; readAddress SHALL remain stable throughout.
REQ-028 SHALL move REQ to COLLECT unconditionally after one cycle; rDataReady SHALL be 1 only in COLLECT.
REQ-029 SHALL, in COLLECT, on rDataValid and rDataReady: write rData into lane counter if loadMask[counter]=1, otherwise write zero; then increment the 4-bit (clog2 LANES) counter.
REQ-030 SHALL move COLLECT to DRAIN when the LANES-th beat is accepted; further rDataValid SHALL be ignored.
REQ-031 SHALL move DRAIN to RESP on rDone.
REQ-032 SHALL, when rDone arrives in COLLECT before LANES beats: set resultErr=1, leave unfilled lanes at zero, and move to RESP; a beat coincident with rDone SHALL still be written.
REQ-033 SHALL hold resultValid=1 in RESP, with resultData, resultMask, resultTag and resultErr stable until resultReady=1, and then return to IDLE; loadReady SHALL be 1 in the following cycle.
REQ-034 SHALL ignore rDataValid and rDone in IDLE, REQ (rDone only) and RESP.
REQ-035 SHALL give a minimum latency, from accept to resultValid, of LANES+3 cycles with back-to-back beats and rDone one cycle after the last beat.

Reset
REQ-036 SHALL, while rst=1, force state IDLE, loadReady=1, initRead=0, rDataReady=0, resultValid=0, resultErr=0, counter=0, readAddress=0, resultData=0, resultMask=0 and resultTag=0.
REQ-037 SHALL, when rst is asserted mid-burst, discard the partial vector, produce no resultValid, and ignore subsequent beats.

Verification
REQ-038 SHALL cover a full load: loadAddr[0]=0x1000, mask=0xFFFF, tag=7, 16 beats of data 0..15, then rDone -> readAddress=0x1000, readLen=16, resultData lane i=i, resultTag=7, resultErr=0.
REQ-039 SHALL cover a masked load: mask=0x00F0 with beats 0xA0..0xAF -> lanes 4-7 = 0xA4..0xA7, all others 0.
REQ-040 SHALL cover a truncated burst: rDone after 10 beats -> resultErr=1 and lanes 10-15 = 0.
REQ-041 SHALL cover backpressure: resultReady held 0 for 5 cycles -> resultValid and data stable, loadReady=0, and a new loadValid is not accepted.
REQ-042 SHALL cover reset mid-burst: rst asserted after beat 6 -> all outputs at reset values next cycle, and no resultValid afterwards.
REQ-043 SHALL cover extra beats: a 17th rDataValid -> rDataReady=0 and lane 15 unchanged.
